// File: rtl/axil_pkg.sv
`default_nettype none
// ============================================================================
// Package : axil_pkg
// Brief   : AXI4-Lite response codes and FSM state encodings for the BRAM responder.
// Rev     : 1.0  initial release
// ============================================================================
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_GOT_AW = 2'd1,
    W_GOT_W  = 2'd2,
    W_RESP   = 2'd3
  } WrState;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } RdState;

endpackage
`default_nettype wire

// File: rtl/bram_sdp_bytewe.sv
`default_nettype none
// ============================================================================
// Module : bram_sdp_bytewe
// Brief  : Simple dual-port word array, per-byte write enable, registered
//          read-first read port. No reset on storage or read register.
// Rev    : 1.0  initial release
// ============================================================================
module bram_sdp_bytewe #(
  parameter int DEPTH      = 8192,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_W     = 13
) (
  input  logic                    clk,
  input  logic [DATA_WIDTH/8-1:0] we,
  input  logic [ADDR_W-1:0]       waddr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic                    re,
  input  logic [ADDR_W-1:0]       raddr,
  output logic [DATA_WIDTH-1:0]   rdata
);

  localparam int c_strb_w = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    for (int b = 0; b < c_strb_w; b++) begin
      if (we[b]) begin
        r_mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  // Non-blocking read alongside the write gives old data on a same-word collision.
  always_ff @(posedge clk) begin
    if (re) begin
      r_rdata <= r_mem[raddr];
    end
  end

  assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/axil_bram_responder.sv
`default_nettype none
// ============================================================================
// Module : axil_bram_responder
// Brief  : AXI4-Lite slave in front of an on-chip word memory; independent
//          write (AW/W/B) and read (AR/R) FSMs sharing one byte-writable array.
// Rev    : 1.0  initial release
// ============================================================================
module axil_bram_responder
  import axil_pkg::*;
#(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8192
) (
  input  logic                    clk,
  input  logic                    axi_aresetn,
  input  logic [ADDR_WIDTH-1:0]   axi_awaddr,
  input  logic [2:0]              axi_awprot,
  input  logic                    axi_awvalid,
  output logic                    axi_awready,
  input  logic [DATA_WIDTH-1:0]   axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] axi_wstrb,
  input  logic                    axi_wvalid,
  output logic                    axi_wready,
  output logic [1:0]              axi_bresp,
  output logic                    axi_bvalid,
  input  logic                    axi_bready,
  input  logic [ADDR_WIDTH-1:0]   axi_araddr,
  input  logic [2:0]              axi_arprot,
  input  logic                    axi_arvalid,
  output logic                    axi_arready,
  output logic [DATA_WIDTH-1:0]   axi_rdata,
  output logic [1:0]              axi_rresp,
  output logic                    axi_rvalid,
  input  logic                    axi_rready
);

  localparam int c_strb_w = DATA_WIDTH / 8;
  localparam int c_idx_w  = ADDR_WIDTH - 2;
  localparam int c_mem_aw = $clog2(DEPTH);
  // One extra bit so DEPTH itself is representable for the range compare.
  localparam logic [c_idx_w:0] c_depth = (c_idx_w + 1)'(DEPTH);

  // ---------------------------------------------------------------- write side
  WrState r_wr_state, w_wr_state_nxt;

  logic                  r_awready, r_wready, r_bvalid;
  logic [1:0]            r_bresp;
  logic                  w_awready_nxt, w_wready_nxt, w_bvalid_nxt;
  logic [1:0]            w_bresp_nxt;
  logic [c_idx_w-1:0]    r_aw_idx;
  logic [DATA_WIDTH-1:0] r_w_data;
  logic [c_strb_w-1:0]   r_w_strb;

  logic                  w_aw_hs, w_w_hs, w_b_hs, w_commit, w_cm_ok;
  logic [c_idx_w-1:0]    w_cm_idx;
  logic [DATA_WIDTH-1:0] w_cm_data;
  logic [c_strb_w-1:0]   w_cm_strb, w_mem_we;

  assign w_aw_hs = axi_awvalid & r_awready;
  assign w_w_hs  = axi_wvalid & r_wready;
  assign w_b_hs  = r_bvalid & axi_bready;

  assign w_commit = ((r_wr_state == W_IDLE)   & w_aw_hs & w_w_hs) |
                    ((r_wr_state == W_GOT_AW) & w_w_hs)           |
                    ((r_wr_state == W_GOT_W)  & w_aw_hs);

  assign w_cm_idx  = (r_wr_state == W_GOT_AW) ? r_aw_idx : axi_awaddr[ADDR_WIDTH-1:2];
  assign w_cm_data = (r_wr_state == W_GOT_W)  ? r_w_data : axi_wdata;
  assign w_cm_strb = (r_wr_state == W_GOT_W)  ? r_w_strb : axi_wstrb;
  assign w_cm_ok   = ({1'b0, w_cm_idx} < c_depth);
  assign w_mem_we  = (w_commit && w_cm_ok) ? w_cm_strb : '0;

  always_ff @(posedge clk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      r_wr_state <= W_IDLE;
    end else begin
      r_wr_state <= w_wr_state_nxt;
    end
  end

  always_comb begin
    w_wr_state_nxt = r_wr_state;
    case (r_wr_state)
      W_IDLE: begin
        if (w_aw_hs && w_w_hs) w_wr_state_nxt = W_RESP;
        else if (w_aw_hs)      w_wr_state_nxt = W_GOT_AW;
        else if (w_w_hs)       w_wr_state_nxt = W_GOT_W;
      end
      W_GOT_AW: if (w_w_hs)  w_wr_state_nxt = W_RESP;
      W_GOT_W:  if (w_aw_hs) w_wr_state_nxt = W_RESP;
      W_RESP:   if (w_b_hs)  w_wr_state_nxt = W_IDLE;
      default:               w_wr_state_nxt = W_IDLE;
    endcase
  end

  // Outputs are registered: derive their next values from the next state.
  always_comb begin
    w_awready_nxt = (w_wr_state_nxt == W_IDLE) || (w_wr_state_nxt == W_GOT_W);
    w_wready_nxt  = (w_wr_state_nxt == W_IDLE) || (w_wr_state_nxt == W_GOT_AW);
    w_bvalid_nxt  = (w_wr_state_nxt == W_RESP);
    w_bresp_nxt   = r_bresp;
    if (w_commit) begin
      w_bresp_nxt = w_cm_ok ? RESP_OKAY : RESP_SLVERR;
    end
  end

  always_ff @(posedge clk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_aw_idx  <= '0;
      r_w_data  <= '0;
      r_w_strb  <= '0;
    end else begin
      r_awready <= w_awready_nxt;
      r_wready  <= w_wready_nxt;
      r_bvalid  <= w_bvalid_nxt;
      r_bresp   <= w_bresp_nxt;
      if (w_aw_hs) r_aw_idx <= axi_awaddr[ADDR_WIDTH-1:2];
      if (w_w_hs) begin
        r_w_data <= axi_wdata;
        r_w_strb <= axi_wstrb;
      end
    end
  end

  assign axi_awready = r_awready;
  assign axi_wready  = r_wready;
  assign axi_bvalid  = r_bvalid;
  assign axi_bresp   = r_bresp;

  // ----------------------------------------------------------------- read side
  RdState r_rd_state, w_rd_state_nxt;

  logic               r_arready, r_rvalid;
  logic [1:0]         r_rresp;
  logic               w_arready_nxt, w_rvalid_nxt;
  logic [1:0]         w_rresp_nxt;
  logic               w_ar_hs, w_r_hs, w_ar_ok, w_mem_re;
  logic [c_idx_w-1:0] w_ar_idx;
  logic [DATA_WIDTH-1:0] w_mem_q;

  assign w_ar_hs  = axi_arvalid & r_arready;
  assign w_r_hs   = r_rvalid & axi_rready;
  assign w_ar_idx = axi_araddr[ADDR_WIDTH-1:2];
  assign w_ar_ok  = ({1'b0, w_ar_idx} < c_depth);
  assign w_mem_re = w_ar_hs & w_ar_ok;

  always_ff @(posedge clk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      r_rd_state <= R_IDLE;
    end else begin
      r_rd_state <= w_rd_state_nxt;
    end
  end

  always_comb begin
    w_rd_state_nxt = r_rd_state;
    case (r_rd_state)
      R_IDLE:  if (w_ar_hs) w_rd_state_nxt = R_RESP;
      R_RESP:  if (w_r_hs)  w_rd_state_nxt = R_IDLE;
      default:              w_rd_state_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    w_arready_nxt = (w_rd_state_nxt == R_IDLE);
    w_rvalid_nxt  = (w_rd_state_nxt == R_RESP);
    w_rresp_nxt   = r_rresp;
    if (w_ar_hs) begin
      w_rresp_nxt = w_ar_ok ? RESP_OKAY : RESP_SLVERR;
    end
  end

  always_ff @(posedge clk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rresp   <= RESP_OKAY;
    end else begin
      r_arready <= w_arready_nxt;
      r_rvalid  <= w_rvalid_nxt;
      r_rresp   <= w_rresp_nxt;
    end
  end

  // The array read register has no reset, so mask it outside valid OKAY beats.
  assign axi_rdata   = (r_rvalid && (r_rresp == RESP_OKAY)) ? w_mem_q : '0;
  assign axi_arready = r_arready;
  assign axi_rvalid  = r_rvalid;
  assign axi_rresp   = r_rresp;

  // ------------------------------------------------------------------- storage
  bram_sdp_bytewe #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_W     (c_mem_aw)
  ) u_mem (
    .clk   (clk),
    .we    (w_mem_we),
    .waddr (w_cm_idx[c_mem_aw-1:0]),
    .wdata (w_cm_data),
    .re    (w_mem_re),
    .raddr (w_ar_idx[c_mem_aw-1:0]),
    .rdata (w_mem_q)
  );

  logic w_unused;
  assign w_unused = ^{axi_awprot, axi_arprot, axi_awaddr[1:0], axi_araddr[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_axil_bram_responder.sv
`default_nettype none
// ============================================================================
// Module : tb_axil_bram_responder
// Brief  : Directed self-checking bench for axil_bram_responder (DEPTH=1024).
// Rev    : 1.0  initial release
// ============================================================================
module tb_axil_bram_responder;

  logic        clk = 1'b0;
  logic        axi_aresetn;
  logic [14:0] axi_awaddr, axi_araddr;
  logic [2:0]  axi_awprot, axi_arprot;
  logic        axi_awvalid, axi_wvalid, axi_bready, axi_arvalid, axi_rready;
  logic        axi_awready, axi_wready, axi_bvalid, axi_arready, axi_rvalid;
  logic [31:0] axi_wdata, axi_rdata;
  logic [3:0]  axi_wstrb;
  logic [1:0]  axi_bresp, axi_rresp;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  axil_bram_responder #(
    .ADDR_WIDTH (15),
    .DATA_WIDTH (32),
    .DEPTH      (1024)
  ) dut (
    .clk         (clk),
    .axi_aresetn (axi_aresetn),
    .axi_awaddr  (axi_awaddr),
    .axi_awprot  (axi_awprot),
    .axi_awvalid (axi_awvalid),
    .axi_awready (axi_awready),
    .axi_wdata   (axi_wdata),
    .axi_wstrb   (axi_wstrb),
    .axi_wvalid  (axi_wvalid),
    .axi_wready  (axi_wready),
    .axi_bresp   (axi_bresp),
    .axi_bvalid  (axi_bvalid),
    .axi_bready  (axi_bready),
    .axi_araddr  (axi_araddr),
    .axi_arprot  (axi_arprot),
    .axi_arvalid (axi_arvalid),
    .axi_arready (axi_arready),
    .axi_rdata   (axi_rdata),
    .axi_rresp   (axi_rresp),
    .axi_rvalid  (axi_rvalid),
    .axi_rready  (axi_rready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input string tag, input logic [14:0] a, input logic [31:0] d,
                    input logic [3:0] s, input logic [1:0] exp_resp);
    axi_awaddr = a; axi_wdata = d; axi_wstrb = s;
    axi_awvalid = 1'b1; axi_wvalid = 1'b1;
    tick();
    axi_awvalid = 1'b0; axi_wvalid = 1'b0;
    check({tag, "_bvalid"}, 32'(axi_bvalid), 32'd1);
    check({tag, "_bresp"}, 32'(axi_bresp), 32'(exp_resp));
    axi_bready = 1'b1;
    tick();
    axi_bready = 1'b0;
    check({tag, "_bdone"}, 32'({axi_bvalid, axi_awready, axi_wready}), 32'b011);
  endtask

  task automatic rd(input string tag, input logic [14:0] a, input logic [31:0] exp_data,
                    input logic [1:0] exp_resp);
    axi_araddr = a; axi_arvalid = 1'b1;
    tick();
    axi_arvalid = 1'b0;
    check({tag, "_rvalid"}, 32'(axi_rvalid), 32'd1);
    check({tag, "_rdata"}, axi_rdata, exp_data);
    check({tag, "_rresp"}, 32'(axi_rresp), 32'(exp_resp));
    axi_rready = 1'b1;
    tick();
    axi_rready = 1'b0;
    check({tag, "_rdone"}, 32'({axi_rvalid, axi_arready}), 32'b01);
  endtask

  function automatic logic [31:0] all_outs();
    return {14'd0, axi_awready, axi_wready, axi_bvalid, axi_bresp,
            axi_arready, axi_rvalid, axi_rresp, 9'd0} | axi_rdata;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    axi_aresetn = 1'b0;
    axi_awaddr = '0; axi_araddr = '0; axi_awprot = 3'b010; axi_arprot = 3'b101;
    axi_awvalid = 0; axi_wvalid = 0; axi_bready = 0; axi_arvalid = 0; axi_rready = 0;
    axi_wdata = '0; axi_wstrb = '0;

    // Reset and release
    repeat (5) tick();
    check("reset_outs", all_outs(), 32'd0);
    axi_aresetn = 1'b1;
    #1;
    check("release_pre_edge", 32'({axi_awready, axi_wready, axi_arready}), 32'b000);
    tick();
    check("release_readies", 32'({axi_awready, axi_wready, axi_arready}), 32'b111);
    check("release_valids", 32'({axi_bvalid, axi_rvalid}), 32'b00);

    // Basic write/read
    wr("wr10", 15'h0010, 32'hDEADBEEF, 4'hF, 2'b00);
    rd("rd10", 15'h0010, 32'hDEADBEEF, 2'b00);

    // Zero strobe: OKAY, nothing written
    wr("wr10_s0", 15'h0010, 32'h00000000, 4'h0, 2'b00);
    rd("rd10_s0", 15'h0010, 32'hDEADBEEF, 2'b00);

    // W ahead of AW with partial strobe
    wr("wr20_ff", 15'h0020, 32'hFFFFFFFF, 4'hF, 2'b00);
    axi_wdata = 32'h11223344; axi_wstrb = 4'b0101; axi_wvalid = 1'b1;
    tick();
    axi_wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("w_first_ready", 32'({axi_wready, axi_awready, axi_bvalid}), 32'b010);
      if (i < 2) tick();
    end
    axi_awaddr = 15'h0020; axi_awvalid = 1'b1;
    tick();
    axi_awvalid = 1'b0;
    check("w_first_bvalid", 32'({axi_bvalid, axi_bresp}), 32'b100);
    axi_bready = 1'b1; tick(); axi_bready = 1'b0;
    rd("rd20", 15'h0020, 32'hFF22FF44, 2'b00);

    // Back-pressure on B and R with new requests waiting
    axi_awaddr = 15'h0030; axi_wdata = 32'h12345678; axi_wstrb = 4'hF;
    axi_araddr = 15'h0010;
    axi_awvalid = 1'b1; axi_wvalid = 1'b1; axi_arvalid = 1'b1;
    tick();
    axi_wvalid = 1'b0;
    axi_awaddr = 15'h0040; axi_araddr = 15'h0020;
    for (int i = 0; i < 4; i++) begin
      check("bp_valids", 32'({axi_bvalid, axi_bresp, axi_rvalid, axi_rresp}), 32'b100100);
      check("bp_rdata", axi_rdata, 32'hDEADBEEF);
      check("bp_readies", 32'({axi_awready, axi_wready, axi_arready}), 32'b000);
      tick();
    end
    check("bp_end_valids", 32'({axi_bvalid, axi_rvalid}), 32'b11);
    check("bp_end_rdata", axi_rdata, 32'hDEADBEEF);
    axi_awvalid = 1'b0; axi_arvalid = 1'b0;
    axi_bready = 1'b1; axi_rready = 1'b1;
    tick();
    axi_bready = 1'b0; axi_rready = 1'b0;
    check("bp_release", 32'({axi_bvalid, axi_rvalid, axi_awready, axi_wready, axi_arready}),
          32'b00111);
    rd("rd30", 15'h0030, 32'h12345678, 2'b00);

    // Range boundaries
    wr("wr0", 15'h0000, 32'h01020304, 4'hF, 2'b00);
    wr("wr_last", 15'h0FFC, 32'hA5A5C3C3, 4'hF, 2'b00);
    rd("rd_last", 15'h0FFC, 32'hA5A5C3C3, 2'b00);
    wr("wr_oor", 15'h1000, 32'hCAFEF00D, 4'hF, 2'b10);
    rd("rd_oor", 15'h1000, 32'h00000000, 2'b10);
    rd("rd0_after_oor", 15'h0000, 32'h01020304, 2'b00);

    // Same-edge read/write collision: read-first
    wr("wr50", 15'h0050, 32'h55555555, 4'hF, 2'b00);
    axi_awaddr = 15'h0050; axi_wdata = 32'hAAAAAAAA; axi_wstrb = 4'hF; axi_araddr = 15'h0050;
    axi_awvalid = 1'b1; axi_wvalid = 1'b1; axi_arvalid = 1'b1;
    tick();
    axi_awvalid = 1'b0; axi_wvalid = 1'b0; axi_arvalid = 1'b0;
    check("coll_rdata", axi_rdata, 32'h55555555);
    check("coll_valids", 32'({axi_bvalid, axi_rvalid}), 32'b11);
    axi_bready = 1'b1; axi_rready = 1'b1;
    tick();
    axi_bready = 1'b0; axi_rready = 1'b0;
    rd("rd50_new", 15'h0050, 32'hAAAAAAAA, 2'b00);

    // Reset while holding only the write address
    wr("wr60", 15'h0060, 32'h13579BDF, 4'hF, 2'b00);
    axi_awaddr = 15'h0060; axi_awvalid = 1'b1;
    tick();
    axi_awvalid = 1'b0;
    check("got_aw_readies", 32'({axi_awready, axi_wready}), 32'b01);
    axi_wdata = 32'h00000000; axi_wstrb = 4'hF;
    axi_aresetn = 1'b0;
    #1;
    check("mid_reset_outs", all_outs(), 32'd0);
    repeat (2) tick();
    axi_aresetn = 1'b1;
    tick();
    check("post_reset_idle", 32'({axi_awready, axi_wready, axi_arready, axi_bvalid, axi_rvalid}),
          32'b11100);
    rd("rd60_kept", 15'h0060, 32'h13579BDF, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
